pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stage enable / flush bit positions and the canned control vectors built from them.
package pipe_ctrl_pkg;
  localparam int REGW_DEF = 5;
  localparam int CNTW_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int EN_PC    = 0;
  localparam int EN_IFID  = 1;
  localparam int EN_IDEX  = 2;
  localparam int EN_EXMEM = 3;
  localparam int EN_MEMWB = 4;

  localparam int FL_IFID  = 0;
  localparam int FL_IDEX  = 1;
  localparam int FL_EXMEM = 2;

  localparam logic [4:0] EN_ALL = 5'((1 << EN_PC) | (1 << EN_IFID) | (1 << EN_IDEX) |
                                     (1 << EN_EXMEM) | (1 << EN_MEMWB));
  localparam logic [4:0] EN_LU  = EN_ALL & ~5'((1 << EN_PC) | (1 << EN_IFID));
  localparam logic [4:0] EN_MC  = 5'(1 << EN_MEMWB);

  localparam logic [2:0] FL_LU  = 3'(1 << FL_IDEX);
  localparam logic [2:0] FL_BR  = 3'((1 << FL_IFID) | (1 << FL_IDEX));
  localparam logic [2:0] FL_MC  = 3'(1 << FL_EXMEM);
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; one-cycle update latency, never blocks.
module sat_counter #(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller; zero-latency combinational controls from state+inputs.
// A pending memory access freezes every stage and parks the FSM until it completes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW = REGW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_br_taken,
  input  logic            ex_mc_op,
  input  logic            mc_done,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic [4:0]      en_o,
  output logic [2:0]      flush_o,
  output logic            mc_go,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);
  state_t state, state_nx, ret_state, ret_nx, eff;
  logic   done_lat, done_nx;
  logic   mem_stall, load_use;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    en_o     = EN_ALL;
    flush_o  = '0;
    mc_go    = 1'b0;
    state_nx = state;
    ret_nx   = ret_state;
    done_nx  = done_lat;
    // On the cycle memory completes we act as the parked state would.
    eff      = (state == ST_MEM_WAIT) ? ret_state : state;

    if (!rst) begin
      flush_o  = '1;
      state_nx = ST_RUN;
      ret_nx   = ST_RUN;
      done_nx  = 1'b0;
    end else if (mem_stall) begin
      en_o     = '0;
      state_nx = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT)
        ret_nx = state;
      if ((state == ST_MC_WAIT) && mc_done)
        done_nx = 1'b1;
    end else if (eff == ST_MC_WAIT) begin
      if (mc_done || done_lat) begin
        state_nx = ST_RUN;
        done_nx  = 1'b0;
      end else begin
        en_o     = EN_MC;
        flush_o  = FL_MC;
        state_nx = ST_MC_WAIT;
      end
    end else begin
      state_nx = ST_RUN;
      if (ex_mc_op) begin
        mc_go    = 1'b1;
        en_o     = EN_MC;
        flush_o  = FL_MC;
        state_nx = ST_MC_WAIT;
      end else if (ex_br_taken) begin
        flush_o  = FL_BR;
      end else if (load_use) begin
        en_o     = EN_LU;
        flush_o  = FL_LU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      done_lat  <= 1'b0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      done_lat  <= done_nx;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!en_o[EN_PC]),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_o != '0),
    .cnt (flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model and literal pins.
module tb_pipe_hazard_ctrl;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic          ex_mc_op, mc_done, mem_req, mem_ready;
  logic [4:0]    en_o;
  logic [2:0]    flush_o;
  logic          mc_go;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: multi-cycle op outstanding, completion seen during a memory stall.
  bit m_busy = 1'b0;
  bit m_pend = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(RW), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .en_o(en_o), .flush_o(flush_o), .mc_go(mc_go),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cyc_begin();
    @(posedge clk); #1;
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_br_taken = 0;
    ex_mc_op = 0; mc_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic cyc_end();
    @(negedge clk); #1;
  endtask

  task automatic idle_cycle();
    cyc_begin(); cyc_end();
  endtask

  task automatic reset_cycle();
    cyc_begin(); rst = 1'b0; cyc_end();
  endtask

  task automatic pin(input string name, input logic [4:0] en, input logic [2:0] fl, input logic go);
    check({name, ".en"}, int'(en_o), int'(en));
    check({name, ".flush"}, int'(flush_o), int'(fl));
    check({name, ".go"}, int'(mc_go), int'(go));
  endtask

  always @(negedge clk) begin
    logic [4:0] e_en;
    logic [2:0] e_fl;
    logic       e_go;
    bit         ms, lu;
    ms = mem_req && !mem_ready;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_go = 1'b0;
    e_fl = 3'b000;
    e_en = 5'b11111;
    if (!rst)             e_fl = 3'b111;
    else if (ms)          e_en = 5'b00000;
    else if (m_busy) begin
      if (!(mc_done || m_pend)) begin e_en = 5'b10000; e_fl = 3'b100; end
    end
    else if (ex_mc_op)    begin e_go = 1'b1; e_en = 5'b10000; e_fl = 3'b100; end
    else if (ex_br_taken) e_fl = 3'b011;
    else if (lu)          begin e_en = 5'b11100; e_fl = 3'b010; end

    check("mdl.en", int'(en_o), int'(e_en));
    check("mdl.flush", int'(flush_o), int'(e_fl));
    check("mdl.go", int'(mc_go), int'(e_go));
    check("mdl.stall_cnt", int'(stall_cnt), m_stall);
    check("mdl.flush_cnt", int'(flush_cnt), m_flush);

    if (!rst) begin
      m_busy = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_en[0] && m_stall < MAXC) m_stall++;
      if (e_fl != 0 && m_flush < MAXC) m_flush++;
      if (ms) begin
        if (m_busy && mc_done) m_pend = 1;
      end else if (m_busy) begin
        if (mc_done || m_pend) begin m_busy = 0; m_pend = 0; end
      end else if (ex_mc_op) m_busy = 1;
    end
  end

  initial begin
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_br_taken = 0;
    ex_mc_op = 0; mc_done = 0; mem_req = 0; mem_ready = 0;

    reset_cycle(); reset_cycle();
    pin("reset", 5'b11111, 3'b111, 1'b0);
    check("reset.stall_cnt", int'(stall_cnt), 0);
    check("reset.flush_cnt", int'(flush_cnt), 0);

    // Load-use on rs1 gives exactly one bubble.
    cyc_begin(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; cyc_end();
    pin("lu_rs1", 5'b11100, 3'b010, 1'b0);
    idle_cycle();
    pin("lu_after", 5'b11111, 3'b000, 1'b0);
    check("lu.stall_cnt", int'(stall_cnt), 1);
    check("lu.flush_cnt", int'(flush_cnt), 1);

    cyc_begin(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; cyc_end();
    pin("lu_x0", 5'b11111, 3'b000, 1'b0);
    cyc_begin(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; cyc_end();
    pin("lu_rs2", 5'b11100, 3'b010, 1'b0);
    cyc_begin(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; cyc_end();
    pin("lu_unused", 5'b11111, 3'b000, 1'b0);

    // Branch beats load-use.
    reset_cycle();
    cyc_begin(); ex_br_taken = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; cyc_end();
    pin("br_lu", 5'b11111, 3'b011, 1'b0);
    idle_cycle();
    check("br.stall_cnt", int'(stall_cnt), 0);
    check("br.flush_cnt", int'(flush_cnt), 1);

    // Multi-cycle op: issue cycle + 4 waiting cycles, done on the sixth.
    reset_cycle();
    cyc_begin(); ex_mc_op = 1; ex_br_taken = 1; cyc_end();
    pin("mc_issue", 5'b10000, 3'b100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      pin("mc_wait", 5'b10000, 3'b100, 1'b0);
    end
    cyc_begin(); mc_done = 1; cyc_end();
    pin("mc_done", 5'b11111, 3'b000, 1'b0);
    idle_cycle();
    check("mc.stall_cnt", int'(stall_cnt), 5);
    check("mc.flush_cnt", int'(flush_cnt), 5);

    // Memory stall swallowing the completion during MC_WAIT.
    reset_cycle();
    cyc_begin(); ex_mc_op = 1; cyc_end();
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      cyc_begin(); mem_req = 1; mc_done = (i == 0); cyc_end();
      pin("mcmem_stall", 5'b00000, 3'b000, 1'b0);
    end
    cyc_begin(); mem_req = 1; mem_ready = 1; cyc_end();
    pin("mcmem_resume", 5'b11111, 3'b000, 1'b0);
    idle_cycle();
    pin("mcmem_run", 5'b11111, 3'b000, 1'b0);

    // Reset while parked in MEM_WAIT with a multi-cycle op outstanding.
    reset_cycle();
    cyc_begin(); ex_mc_op = 1; cyc_end();
    for (int i = 0; i < 2; i++) begin cyc_begin(); mem_req = 1; cyc_end(); end
    cyc_begin(); mem_req = 1; rst = 0; cyc_end();
    pin("rst_mem", 5'b11111, 3'b111, 1'b0);
    idle_cycle();
    pin("rst_after", 5'b11111, 3'b000, 1'b0);
    check("rst.stall_cnt", int'(stall_cnt), 0);
    check("rst.flush_cnt", int'(flush_cnt), 0);
    idle_cycle();
    pin("rst_run", 5'b11111, 3'b000, 1'b0);

    // mc_done ignored in RUN; memory stall defers the mc_go pulse.
    cyc_begin(); mc_done = 1; cyc_end();
    pin("done_in_run", 5'b11111, 3'b000, 1'b0);
    cyc_begin(); ex_mc_op = 1; mem_req = 1; cyc_end();
    pin("mc_memstall", 5'b00000, 3'b000, 1'b0);
    cyc_begin(); ex_mc_op = 1; mem_req = 1; mem_ready = 1; cyc_end();
    pin("mc_after_mem", 5'b10000, 3'b100, 1'b1);
    cyc_begin(); mc_done = 1; cyc_end();
    pin("mc_after_done", 5'b11111, 3'b000, 1'b0);

    // Counter saturation.
    reset_cycle();
    for (int i = 0; i < 20; i++) begin cyc_begin(); mem_req = 1; cyc_end(); end
    idle_cycle();
    check("sat.stall_cnt", int'(stall_cnt), MAXC);
    check("sat.flush_cnt", int'(flush_cnt), 0);

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
